// File: rtl/blft_win_sched.sv
// Window-fetch scheduler for the bilateral filter: walks the image column by column over the
// (2*RAD+1)-row band of each output row, issuing one read per cycle plus window strobes.
module blft_win_sched #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int RAD   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [15:0] rd_addr,
  output logic        col_first,
  output logic        row_first,
  output logic        win_valid,
  output logic [15:0] pix_addr,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE, FETCH, ROWEND, DONE} state_t;

  localparam logic [7:0] R8       = 8'(RAD);
  localparam logic [7:0] R2       = 8'(2 * RAD);
  localparam logic [7:0] LAST_COL = 8'(IMG_W - 1);
  localparam logic [7:0] LAST_PR  = 8'(IMG_H - 1 - RAD);

  state_t     state;
  logic [7:0] pr;
  logic [7:0] col;
  logic [7:0] row;

  assign state_dbg = state;

  // Handshake: a beat moves when rd_valid && rd_ready at a rising edge; while stalled,
  // rd_addr, col_first and row_first hold and no counter advances.
  // Outputs are loaded with the values of the next beat so they stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pr        <= '0;
      col       <= '0;
      row       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      col_first <= 1'b0;
      row_first <= 1'b0;
      win_valid <= 1'b0;
      pix_addr  <= '0;
    end else begin
      win_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            busy      <= 1'b1;
            pr        <= R8;
            col       <= '0;
            row       <= '0;
            rd_valid  <= 1'b1;
            rd_addr   <= '0;
            col_first <= 1'b1;
            row_first <= 1'b1;
          end
        end
        FETCH: begin
          if (rd_ready) begin
            if (row != pr + R8) begin
              row       <= row + 8'd1;
              rd_addr   <= {row + 8'd1, col};
              col_first <= 1'b0;
            end else begin
              row <= pr - R8;
              col <= col + 8'd1;
              if (col >= R2) begin
                win_valid <= 1'b1;
                pix_addr  <= {pr, col - R8};
              end
              if (col == LAST_COL) begin
                rd_valid  <= 1'b0;
                col_first <= 1'b0;
                row_first <= 1'b0;
                if (pr == LAST_PR) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state <= ROWEND;
                end
              end else begin
                rd_addr   <= {pr - R8, col + 8'd1};
                col_first <= 1'b1;
                row_first <= 1'b0;
              end
            end
          end
        end
        ROWEND: begin
          state     <= FETCH;
          pr        <= pr + 8'd1;
          row       <= pr + 8'd1 - R8;
          col       <= '0;
          rd_valid  <= 1'b1;
          rd_addr   <= {pr + 8'd1 - R8, 8'd0};
          col_first <= 1'b1;
          row_first <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/blft_win_sched.md
# blft_win_sched

Window-fetch scheduler for the bilateral filter datapath. On `start`, it walks the image in filter order and issues one read address per cycle to the image memory port. For each output row it fetches every column, top to bottom, over the (2·RAD+1)-row band around that row. It also emits the strobes the window datapath needs: column boundaries, row restart, and "window complete" with the output pixel address.

## Interface
- `IMG_W`, default 256: image width in pixels; 2·RAD+1 ≤ `IMG_W` ≤ 256.
- `IMG_H`, default 256: image height in pixels; 2·RAD+1 ≤ `IMG_H` ≤ 256.
- `RAD`, default 5: filter radius; the window is (2·RAD+1)².
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high. The clock is `clk`.
- `start` input 1: level-sampled. Starts a frame when the block is in IDLE; ignored otherwise.
- `busy` output 1: high in FETCH and ROWEND.
- `done` output 1: one-cycle pulse when the frame is complete.
- `rd_valid` output 1: read request valid.
- `rd_ready` input 1: memory accepts the request. A beat is accepted when `rd_valid` && `rd_ready`.
- `rd_addr` output 16: {row[7:0], col[7:0]} of the requested pixel.
- `col_first` output 1: qualifies `rd_valid`; the beat is the top row of a column.
- `row_first` output 1: qualifies `rd_valid`; the beat belongs to column 0, so the datapath clears its window.
- `win_valid` output 1: one-cycle pulse; the window for `pix_addr` is fully delivered.
- `pix_addr` output 16: {pr, pc} of the output pixel; valid when `win_valid` is high, held otherwise.

## Operation
- Registers: `pr` (output row), `col` (fetch column), `row` (fetch row). All outputs are registered.
- States: IDLE, FETCH, ROWEND, DONE.
- IDLE → FETCH when `start` is high.
  - Load `pr`=RAD, `col`=0, `row`=0.
- FETCH:
  - `rd_valid`=1 and `rd_addr`={`row`, `col`}.
  - On acceptance with `row` < `pr`+RAD: `row`++.
  - On acceptance with `row` = `pr`+RAD (last beat of the column):
    - `row` ← `pr`−RAD and `col`++.
    - If `col` ≥ 2·RAD, pulse `win_valid` next cycle with `pix_addr`={`pr`, `col`−RAD}.
  - On the last beat of column `IMG_W`−1:
    - If `pr` = `IMG_H`−1−RAD → DONE.
    - Otherwise → ROWEND.
- ROWEND (one cycle):
  - `rd_valid`=0.
  - `pr`++, `row` ← `pr`+1−RAD, `col`=0.
  - → FETCH.
- DONE (one cycle): `done`=1 → IDLE.
- Per-beat flags:
  - `col_first` = (`row` = `pr`−RAD).
  - `row_first` = (`col` = 0).
- Counts per frame:
  - Beats: (`IMG_H`−2·RAD)·`IMG_W`·(2·RAD+1).
  - `win_valid` pulses: (`IMG_H`−2·RAD)·(`IMG_W`−2·RAD).
  - ROWEND cycles: `IMG_H`−2·RAD−1.
- Address arithmetic: 8-bit row/col, no wrap. Parameter limits guarantee every address is in range.

## Timing
- Reset values: all outputs 0, state IDLE, internal counters 0.
- `start` is sampled at edge k. `rd_valid` is high in cycle k+1 with `rd_addr`={0, 0}.
- Stall: while `rd_valid` && !`rd_ready`, `rd_addr`, `col_first` and `row_first` hold; no counter advances; no `win_valid`.
- `win_valid` is asserted exactly the cycle after the accepting edge of the last beat of the qualifying column.
- Throughput: one beat per cycle when `rd_ready`=1, with a one-cycle bubble per ROWEND.
- `done` is asserted the cycle after the final accepted beat. It coincides with the final `win_valid`.
- `start` is ignored while `busy` or `done` is high. `start` held high in the `done` cycle is also ignored. A held `start` relaunches from IDLE on the following edge.
- Reset mid-frame: immediate return to IDLE with all outputs 0. No partial-frame `done`.

## Test plan
- Default parameters, `rd_ready`=1, `start` pulse at edge k:
  - Addresses follow 0x0000, 0x0100 … 0x0A00, then 0x0001.
  - First `win_valid` comes after 121 accepted beats, with `pix_addr`=0x0505.
  - 60,516 `win_valid` pulses in total; the last has `pix_addr`=0xFAFA.
  - `done` is high in cycle k+692,982.
- `IMG_W`=8, `IMG_H`=8, `RAD`=1:
  - 144 beats, 36 `win_valid` pulses, 5 ROWEND bubbles.
  - Row 2 starts at `rd_addr`=0x0100 with `row_first`=1 and `col_first`=1.
- Random `rd_ready` (50%), default parameters:
  - The address sequence matches the free-running sequence beat for beat.
  - `rd_addr` is stable during every stall.
  - No `win_valid` pulse occurs in a stall cycle.
- `rst` asserted mid-frame (after 5,000 beats):
  - Outputs go to 0 asynchronously.
  - A new `start` restarts from `rd_addr`=0x0000 and `pix_addr` first at 0x0505.
- `start` held high for the entire frame:
  - Exactly one frame runs until `done`.
  - A second frame begins with `rd_valid` two cycles after `done`.
